fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] word_t;

    // One prefetch FIFO entry: the fetch address and the word read from it.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundle between fetch, instruction memory and decode.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic  imem_ren;
    word_t imem_addr;
    logic  imem_ready;
    word_t imem_rdata;
    logic  redirect_valid;
    word_t redirect_pc;
    logic  halt;
    word_t instr;
    word_t instr_pc;
    logic  instr_valid;
    logic  instr_ready;
    logic  halted;
    logic  fetch_fault;

    modport fu (
        output imem_ren, imem_addr, instr, instr_pc, instr_valid, halted, fetch_fault,
        input  imem_ready, imem_rdata, redirect_valid, redirect_pc, halt, instr_ready
    );

    modport tb (
        input  imem_ren, imem_addr, instr, instr_pc, instr_valid, halted, fetch_fault,
        output imem_ready, imem_rdata, redirect_valid, redirect_pc, halt, instr_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: registered storage, flush clears to empty with pointers at 0.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fetch_entry_t            din,
    output fetch_entry_t            dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over any same-cycle push or pop.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Entry storage; no reset needed since empty slots are never presented.
    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem request, prefetch FIFO, redirect/halt/fault.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC   = RESET_PC_DEFAULT,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic      CLK,
    input  logic      RST,
    fetch_unit_if.fu  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state;
    word_t          pc;
    fetch_entry_t   head;
    fetch_entry_t   din;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic           run;
    logic           accept;
    logic           out_valid;
    logic           pop;
    logic           flush;

    assign run = (state == RUN);

    // Request depends only on state, occupancy and the control inputs so that
    // decode's ready never reaches the memory request combinationally.
    assign bus.imem_ren  = run && !full && !bus.redirect_valid && !bus.halt && !RST;
    assign bus.imem_addr = pc;
    assign accept        = bus.imem_ren && bus.imem_ready;

    assign out_valid       = run && !empty;
    assign bus.instr_valid = out_valid;
    assign bus.instr       = out_valid ? head.instr : '0;
    assign bus.instr_pc    = out_valid ? head.pc    : '0;
    assign pop             = out_valid && bus.instr_ready;

    // Halt and redirect both empty the FIFO; the FIFO drops any same-cycle pop.
    assign flush = run && (bus.halt || bus.redirect_valid);

    assign bus.halted      = (state == HALTED);
    assign bus.fetch_fault = (state == FAULT);

    assign din.pc    = pc;
    assign din.instr = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (accept),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // State and PC: halt beats redirect beats sequential fetch; terminal states hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else if (run) begin
            if (bus.halt) begin
                state <= HALTED;
            end else if (bus.redirect_valid) begin
                pc <= bus.redirect_pc;
                if (bus.redirect_pc[1:0] != 2'b00)
                    state <= FAULT;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, backpressure, redirect, fault, halt, async reset.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_unit_if bus ();

    // Instruction memory returns 0xA0 + address.
    assign bus.imem_rdata = 32'hA0 + bus.imem_addr;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic ok;
        checks   = 0;
        failures = 0;
        clear_inputs();
        rst = 1'b1;
        #1;

        // Reset state
        chk("rst_ren",    {31'b0, bus.imem_ren},    32'd0);
        chk("rst_valid",  {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr",  bus.instr,                32'd0);
        chk("rst_pc",     bus.instr_pc,             32'd0);
        chk("rst_halted", {31'b0, bus.halted},      32'd0);
        chk("rst_fault",  {31'b0, bus.fetch_fault}, 32'd0);
        tick();
        rst = 1'b0;
        #1;

        // Basic stream
        bus.imem_ready  = 1'b1;
        bus.instr_ready = 1'b1;
        #1;
        chk("s_ren0",   {31'b0, bus.imem_ren},    32'd1);
        chk("s_addr0",  bus.imem_addr,            32'h0);
        chk("s_valid0", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        chk("s_valid1", {31'b0, bus.instr_valid}, 32'd1);
        chk("s_pc1",    bus.instr_pc,             32'h0);
        chk("s_ins1",   bus.instr,                32'hA0);
        chk("s_addr1",  bus.imem_addr,            32'h4);
        tick();
        chk("s_pc2",    bus.instr_pc,             32'h4);
        chk("s_ins2",   bus.instr,                32'hA4);
        tick();
        chk("s_pc3",    bus.instr_pc,             32'h8);
        chk("s_ins3",   bus.instr,                32'hA8);

        // Backpressure: FIFO fills after four accepts
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (4) tick();
        chk("bp_ren_full", {31'b0, bus.imem_ren}, 32'd0);
        chk("bp_addr",     bus.imem_addr,         32'h10);
        chk("bp_head",     bus.instr_pc,          32'h0);
        tick();
        chk("bp_ren_hold", {31'b0, bus.imem_ren}, 32'd0);
        chk("bp_addr_hold", bus.imem_addr,        32'h10);
        bus.instr_ready = 1'b1;
        #1;
        chk("bp_no_comb",  {31'b0, bus.imem_ren}, 32'd0);
        tick();
        chk("bp_pop1",     bus.instr_pc,          32'h4);
        chk("bp_reassert", {31'b0, bus.imem_ren}, 32'd1);
        chk("bp_addr2",    bus.imem_addr,         32'h10);
        tick();
        chk("bp_pop2",     bus.instr_pc,          32'h8);
        chk("bp_addr3",    bus.imem_addr,         32'h14);

        // Redirect flush with a same-cycle memory response
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (3) tick();
        chk("rd_pre_addr", bus.imem_addr, 32'hC);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("rd_ren_gate", {31'b0, bus.imem_ren}, 32'd0);
        tick();
        chk("rd_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rd_instr", bus.instr,                32'd0);
        chk("rd_addr",  bus.imem_addr,            32'h100);
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd_ren", {31'b0, bus.imem_ren}, 32'd1);
        tick();
        chk("rd_head_pc",  bus.instr_pc, 32'h100);
        chk("rd_head_ins", bus.instr,    32'h1A0);
        bus.instr_ready = 1'b1;
        tick();
        chk("rd_next_pc", bus.instr_pc, 32'h104);

        // Misaligned redirect faults and holds
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("mf_fault",  {31'b0, bus.fetch_fault}, 32'd1);
        chk("mf_ren",    {31'b0, bus.imem_ren},    32'd0);
        chk("mf_valid",  {31'b0, bus.instr_valid}, 32'd0);
        chk("mf_halted", {31'b0, bus.halted},      32'd0);
        chk("mf_dbg_pc", bus.imem_addr,            32'h102);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.halt           = 1'b1;
        repeat (5) tick();
        chk("mf_hold_fault",  {31'b0, bus.fetch_fault}, 32'd1);
        chk("mf_hold_halted", {31'b0, bus.halted},      32'd0);
        chk("mf_hold_addr",   bus.imem_addr,            32'h102);
        do_reset();
        chk("mf_cleared", {31'b0, bus.fetch_fault}, 32'd0);

        // Halt beats a simultaneous redirect
        bus.imem_ready = 1'b1;
        repeat (2) tick();
        bus.halt           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        tick();
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("h_halted", {31'b0, bus.halted},      32'd1);
        chk("h_ren",    {31'b0, bus.imem_ren},    32'd0);
        chk("h_valid",  {31'b0, bus.instr_valid}, 32'd0);
        chk("h_pc",     bus.instr_pc,             32'd0);
        chk("h_addr",   bus.imem_addr,            32'h8);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.halt           = i[0];
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 32'h200;
            bus.instr_ready    = 1'b1;
            tick();
            if (!(bus.halted === 1'b1 && bus.imem_ren === 1'b0 &&
                  bus.instr_valid === 1'b0 && bus.imem_addr === 32'h8))
                ok = 1'b0;
        end
        chk("h_hold20", {31'b0, ok}, 32'd1);

        // Asynchronous reset mid-stream
        do_reset();
        bus.imem_ready = 1'b1;
        repeat (2) tick();
        chk("ar_pre_valid", {31'b0, bus.instr_valid}, 32'd1);
        chk("ar_pre_addr",  bus.imem_addr,            32'h8);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("ar_instr", bus.instr,                32'd0);
        chk("ar_ren",   {31'b0, bus.imem_ren},    32'd0);
        chk("ar_addr",  bus.imem_addr,            32'h0);
        rst = 1'b0;
        #1;
        chk("ar_rel_ren", {31'b0, bus.imem_ren}, 32'd1);
        tick();
        chk("ar_first_pc", bus.instr_pc, 32'h0);
        chk("ar_first_in", bus.instr,    32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
